// File: rtl/lc3_pkg.sv
// Shared types and encodings for the LC-3 control unit: FSM state enum,
// opcode values and datapath mux-select encodings.
package lc3_pkg;

  typedef enum logic [4:0] {
    S_HALTED   = 5'd0,
    S_FETCH1   = 5'd1,
    S_FETCH2   = 5'd2,
    S_FETCH3   = 5'd3,
    S_DECODE   = 5'd4,
    S_ADD      = 5'd5,
    S_AND      = 5'd6,
    S_NOT      = 5'd7,
    S_BR       = 5'd8,
    S_BR_TAKEN = 5'd9,
    S_JMP      = 5'd10,
    S_JSR1     = 5'd11,
    S_JSR2     = 5'd12,
    S_LDR1     = 5'd13,
    S_LDR2     = 5'd14,
    S_LDR3     = 5'd15,
    S_STR1     = 5'd16,
    S_STR2     = 5'd17,
    S_STR3     = 5'd18,
    S_PAUSE1   = 5'd19,
    S_PAUSE2   = 5'd20
  } ctrl_state_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] PCMUX_BUS   = 2'b00;
  localparam logic [1:0] PCMUX_ADDER = 2'b01;
  localparam logic [1:0] PCMUX_INC   = 2'b10;

  localparam logic [1:0] ADDR2_SEXT11 = 2'b00;
  localparam logic [1:0] ADDR2_SEXT9  = 2'b01;
  localparam logic [1:0] ADDR2_SEXT6  = 2'b10;
  localparam logic [1:0] ADDR2_ZERO   = 2'b11;

  localparam logic [1:0] ALUK_ADD  = 2'b00;
  localparam logic [1:0] ALUK_AND  = 2'b01;
  localparam logic [1:0] ALUK_NOT  = 2'b10;
  localparam logic [1:0] ALUK_PASS = 2'b11;

  // States that hold an SRAM access open for MEM_WAIT cycles
  function automatic logic is_mem_state(input ctrl_state_t s);
    return (s == S_FETCH2) || (s == S_LDR2) || (s == S_STR3);
  endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// 3-bit SRAM wait counter: clears while idle, counts up to MEM_WAIT-1 and
// flags done on the last cycle of the access.
module mem_wait_ctr #(
  parameter int MEM_WAIT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam logic [2:0] LAST = 3'(MEM_WAIT - 1);

  logic [2:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !done) begin
      count <= count + 3'd1;
    end
  end

  assign done = (count == LAST);

endmodule

// File: rtl/lc3_control.sv
// LC-3 instruction sequencing FSM (Moore outputs). Define LC3_JSR_EN to
// build the JSR states; otherwise opcode 0100 decodes as a NOP.
module lc3_control
  import lc3_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic        Clk,
  input  logic        Reset_al,
  input  logic        Run,
  input  logic        Continue,
  input  logic [15:0] IR,
  input  logic        BEN,
  output logic        LD_PC,
  output logic        LD_IR,
  output logic        LD_MAR,
  output logic        LD_MDR,
  output logic        LD_BEN,
  output logic        LD_CC,
  output logic        LD_REG,
  output logic        GatePC,
  output logic        GateMDR,
  output logic        GateALU,
  output logic        GateMARMUX,
  output logic [1:0]  PCMUX,
  output logic [1:0]  ADDR2MUX,
  output logic        ADDR1MUX,
  output logic [1:0]  ALUK,
  output logic        DRMUX,
  output logic        SR1MUX,
  output logic        MIO_EN,
  output logic        Mem_CE,
  output logic        Mem_OE,
  output logic        Mem_WE,
  output logic        Mem_UB,
  output logic        Mem_LB
);

  ctrl_state_t state, next_state;
  logic        in_mem;
  logic        wait_done;
  logic        unused_ir;

  assign unused_ir = ^IR[11:0];
  assign in_mem    = is_mem_state(state);

  // Memory states never follow one another, so clearing whenever we are
  // outside one guarantees the counter starts at zero on every entry.
  mem_wait_ctr #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .clk   (Clk),
    .rst_n (Reset_al),
    .clr   (!in_mem),
    .en    (in_mem),
    .done  (wait_done)
  );

  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) state <= S_HALTED;
    else           state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_HALTED:   if (Run) next_state = S_FETCH1;
      S_FETCH1:   next_state = S_FETCH2;
      S_FETCH2:   if (wait_done) next_state = S_FETCH3;
      S_FETCH3:   next_state = S_DECODE;
      S_DECODE: begin
        case (IR[15:12])
          OP_ADD:   next_state = S_ADD;
          OP_AND:   next_state = S_AND;
          OP_NOT:   next_state = S_NOT;
          OP_BR:    next_state = S_BR;
          OP_JMP:   next_state = S_JMP;
`ifdef LC3_JSR_EN
          OP_JSR:   next_state = S_JSR1;
`endif
          OP_LDR:   next_state = S_LDR1;
          OP_STR:   next_state = S_STR1;
          OP_PAUSE: next_state = S_PAUSE1;
          default:  next_state = S_FETCH1;
        endcase
      end
      S_ADD, S_AND, S_NOT, S_JMP, S_BR_TAKEN, S_LDR3:
                  next_state = S_FETCH1;
      S_BR:       next_state = BEN ? S_BR_TAKEN : S_FETCH1;
`ifdef LC3_JSR_EN
      S_JSR1:     next_state = S_JSR2;
      S_JSR2:     next_state = S_FETCH1;
`endif
      S_LDR1:     next_state = S_LDR2;
      S_LDR2:     if (wait_done) next_state = S_LDR3;
      S_STR1:     next_state = S_STR2;
      S_STR2:     next_state = S_STR3;
      S_STR3:     if (wait_done) next_state = S_FETCH1;
      S_PAUSE1:   if (Continue) next_state = S_PAUSE2;
      S_PAUSE2:   if (!Continue) next_state = S_FETCH1;
      default:    next_state = S_HALTED;
    endcase
  end

  always_comb begin
    LD_PC      = 1'b0;
    LD_IR      = 1'b0;
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = PCMUX_BUS;
    ADDR2MUX   = ADDR2_SEXT11;
    ADDR1MUX   = 1'b0;
    ALUK       = ALUK_ADD;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    MIO_EN     = 1'b0;
    Mem_CE     = 1'b1;
    Mem_OE     = 1'b1;
    Mem_WE     = 1'b1;
    case (state)
      S_FETCH1: begin
        GatePC = 1'b1;
        LD_MAR = 1'b1;
        PCMUX  = PCMUX_INC;
        LD_PC  = 1'b1;
      end
      S_FETCH2, S_LDR2: begin
        Mem_CE = 1'b0;
        Mem_OE = 1'b0;
        MIO_EN = 1'b1;
        LD_MDR = wait_done;
      end
      S_FETCH3: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
      end
      S_DECODE: LD_BEN = 1'b1;
      S_ADD, S_AND, S_NOT: begin
        SR1MUX  = 1'b1;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        ALUK    = (state == S_AND) ? ALUK_AND :
                  (state == S_NOT) ? ALUK_NOT : ALUK_ADD;
      end
      S_BR_TAKEN: begin
        ADDR1MUX = 1'b1;
        ADDR2MUX = ADDR2_SEXT9;
        PCMUX    = PCMUX_ADDER;
        LD_PC    = 1'b1;
      end
      S_JMP: begin
        SR1MUX   = 1'b1;
        ADDR2MUX = ADDR2_ZERO;
        PCMUX    = PCMUX_ADDER;
        LD_PC    = 1'b1;
      end
`ifdef LC3_JSR_EN
      S_JSR1: begin
        GatePC = 1'b1;
        DRMUX  = 1'b1;
        LD_REG = 1'b1;
      end
      S_JSR2: begin
        ADDR1MUX = 1'b1;
        ADDR2MUX = ADDR2_SEXT11;
        PCMUX    = PCMUX_ADDER;
        LD_PC    = 1'b1;
      end
`endif
      S_LDR1, S_STR1: begin
        SR1MUX     = 1'b1;
        ADDR2MUX   = ADDR2_SEXT6;
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
      end
      S_LDR3: begin
        GateMDR = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      // SR1MUX=0 routes IR[11:9] (the store source) through the ALU
      S_STR2: begin
        ALUK    = ALUK_PASS;
        GateALU = 1'b1;
        LD_MDR  = 1'b1;
      end
      S_STR3: begin
        Mem_CE = 1'b0;
        Mem_WE = 1'b0;
      end
      default: ;
    endcase
    Mem_UB = Mem_CE;
    Mem_LB = Mem_CE;
  end

endmodule

// File: tb/tb_lc3_control.sv
// Directed bench for lc3_control (MEM_WAIT=2, LC3_JSR_EN undefined).
module tb_lc3_control;

  logic        Clk = 1'b0;
  logic        Reset_al = 1'b0;
  logic        Run = 1'b0;
  logic        Continue = 1'b0;
  logic [15:0] IR = 16'h0000;
  logic        BEN = 1'b0;
  logic        LD_PC, LD_IR, LD_MAR, LD_MDR, LD_BEN, LD_CC, LD_REG;
  logic        GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0]  PCMUX, ADDR2MUX, ALUK;
  logic        ADDR1MUX, DRMUX, SR1MUX, MIO_EN;
  logic        Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB;

  int compared = 0;
  int mismatched = 0;

  always #5 Clk = ~Clk;

  lc3_control #(.MEM_WAIT(2)) dut (
    .Clk(Clk), .Reset_al(Reset_al), .Run(Run), .Continue(Continue),
    .IR(IR), .BEN(BEN),
    .LD_PC(LD_PC), .LD_IR(LD_IR), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
    .LD_BEN(LD_BEN), .LD_CC(LD_CC), .LD_REG(LD_REG),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ADDR1MUX(ADDR1MUX), .ALUK(ALUK),
    .DRMUX(DRMUX), .SR1MUX(SR1MUX), .MIO_EN(MIO_EN),
    .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB)
  );

  // Control word: loads{PC,IR,MAR,MDR,BEN,CC,REG} gates{PC,MDR,ALU,MARMUX}
  // PCMUX ADDR2MUX ADDR1MUX ALUK DRMUX SR1MUX MIO_EN strobes{CE,OE,WE,UB,LB}
  logic [25:0] ctl;
  assign ctl = {LD_PC, LD_IR, LD_MAR, LD_MDR, LD_BEN, LD_CC, LD_REG,
                GatePC, GateMDR, GateALU, GateMARMUX,
                PCMUX, ADDR2MUX, ADDR1MUX, ALUK, DRMUX, SR1MUX, MIO_EN,
                Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB};

  localparam logic [25:0] W_IDLE   = {7'b0000000, 4'b0000, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 5'b11111};
  localparam logic [25:0] W_FETCH1 = {7'b1010000, 4'b1000, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 5'b11111};
  localparam logic [25:0] W_RD     = {7'b0000000, 4'b0000, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 5'b00100};
  localparam logic [25:0] W_RD_END = {7'b0001000, 4'b0000, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 5'b00100};
  localparam logic [25:0] W_FETCH3 = {7'b0100000, 4'b0100, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 5'b11111};
  localparam logic [25:0] W_DECODE = {7'b0000100, 4'b0000, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 5'b11111};
  localparam logic [25:0] W_ADD    = {7'b0000011, 4'b0010, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 5'b11111};
  localparam logic [25:0] W_AND    = {7'b0000011, 4'b0010, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 5'b11111};
  localparam logic [25:0] W_NOT    = {7'b0000011, 4'b0010, 2'b00, 2'b00, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 5'b11111};
  localparam logic [25:0] W_BRT    = {7'b1000000, 4'b0000, 2'b01, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 5'b11111};
  localparam logic [25:0] W_JMP    = {7'b1000000, 4'b0000, 2'b01, 2'b11, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 5'b11111};
  localparam logic [25:0] W_ADR    = {7'b0010000, 4'b0001, 2'b00, 2'b10, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 5'b11111};
  localparam logic [25:0] W_LDR3   = {7'b0000011, 4'b0100, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 5'b11111};
  localparam logic [25:0] W_STR2   = {7'b0001000, 4'b0010, 2'b00, 2'b00, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 5'b11111};
  localparam logic [25:0] W_WR     = {7'b0000000, 4'b0000, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 5'b01000};

  task automatic compare(input string tag, input logic [25:0] exp);
    compared++;
    assert (ctl === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, ctl, exp);
    end
  endtask

  // Advance one cycle and compare on the falling edge
  task automatic chk(input string tag, input logic [25:0] exp);
    @(negedge Clk);
    compare(tag, exp);
  endtask

  task automatic fetch_decode(input string tag);
    chk({tag, ".fetch2a"}, W_RD);
    chk({tag, ".fetch2b"}, W_RD_END);
    chk({tag, ".fetch3"}, W_FETCH3);
    chk({tag, ".decode"}, W_DECODE);
  endtask

  initial begin
    #2;
    compare("reset_async", W_IDLE);
    chk("reset_held", W_IDLE);
    Reset_al = 1'b1;
    chk("halted_run0", W_IDLE);
    chk("halted_run0b", W_IDLE);
    Run = 1'b1;
    chk("fetch1_start", W_FETCH1);
    Run = 1'b0;

    IR = 16'h1042;
    fetch_decode("add");
    chk("add.exec", W_ADD);
    chk("add.fetch1", W_FETCH1);

    IR = 16'h5042;
    fetch_decode("and");
    chk("and.exec", W_AND);
    chk("and.fetch1", W_FETCH1);

    IR = 16'h9042;
    Run = 1'b1;
    fetch_decode("not");
    chk("not.exec", W_NOT);
    chk("not.fetch1", W_FETCH1);
    Run = 1'b0;

    IR = 16'h0E05; BEN = 1'b1;
    fetch_decode("brt");
    chk("brt.br", W_IDLE);
    chk("brt.taken", W_BRT);
    chk("brt.fetch1", W_FETCH1);

    BEN = 1'b0;
    fetch_decode("brn");
    chk("brn.br", W_IDLE);
    chk("brn.fetch1", W_FETCH1);

    IR = 16'hC1C0;
    fetch_decode("jmp");
    chk("jmp.exec", W_JMP);
    chk("jmp.fetch1", W_FETCH1);

    IR = 16'h4800;
    fetch_decode("jsr_nop");
    chk("jsr_nop.fetch1", W_FETCH1);

    IR = 16'h6282;
    fetch_decode("ldr");
    chk("ldr.addr", W_ADR);
    chk("ldr.rd_a", W_RD);
    chk("ldr.rd_b", W_RD_END);
    chk("ldr.wb", W_LDR3);
    chk("ldr.fetch1", W_FETCH1);

    IR = 16'h7282;
    fetch_decode("str");
    chk("str.addr", W_ADR);
    chk("str.mdr", W_STR2);
    chk("str.wr_a", W_WR);
    chk("str.wr_b", W_WR);
    chk("str.fetch1", W_FETCH1);

    IR = 16'hD000;
    fetch_decode("pause");
    chk("pause1.a", W_IDLE);
    chk("pause1.b", W_IDLE);
    Continue = 1'b1;
    chk("pause2.a", W_IDLE);
    chk("pause2.b", W_IDLE);
    Continue = 1'b0;
    chk("pause.fetch1", W_FETCH1);

    IR = 16'h1042;
    chk("rst.fetch2a", W_RD);
    #2;
    Reset_al = 1'b0;
    #1;
    compare("rst.mid_read", W_IDLE);
    chk("rst.held", W_IDLE);
    Reset_al = 1'b1;
    chk("rst.halted", W_IDLE);
    chk("rst.halted2", W_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lc3_control.md
# lc3_control

Instruction sequencing FSM for the 16-bit LC-3 datapath. It drives every load, gate and mux select of the datapath plus the active-low SRAM strobes, running fetch, decode and execute for the supported opcode subset. It sits beside the datapath in the top level, consuming `IR` and `BEN` and producing all control words. Memory reads stretch over a parameterised number of wait cycles.

## Interface
- `MEM_WAIT`, default 2: cycles an SRAM read/write is held (1–7).
- `Clk` in 1: system clock, rising edge.
- `Reset_al` in 1: asynchronous reset, active-low.
- `Run` in 1: leave HALTED and start fetching.
- `Continue` in 1: release a PAUSE.
- `IR` in 16: current instruction register.
- `BEN` in 1: registered branch-enable from datapath.
- `LD_PC`, `LD_IR`, `LD_MAR`, `LD_MDR`, `LD_BEN`, `LD_CC`, `LD_REG` out 1 each: register load enables.
- `GatePC`, `GateMDR`, `GateALU`, `GateMARMUX` out 1 each: bus drivers, at most one high per cycle.
- `PCMUX` out 2: 00 BUS, 01 adder, 10 PC+1.
- `ADDR2MUX` out 2: 00 SEXT11, 01 SEXT9, 10 SEXT6, 11 zero.
- `ADDR1MUX` out 1: 0 SR1, 1 PC.
- `ALUK` out 2: 00 ADD, 01 AND, 10 NOT, 11 PASS.
- `DRMUX` out 1: 0 IR[11:9], 1 R7.
- `SR1MUX` out 1: 0 IR[11:9], 1 IR[8:6].
- `MIO_EN` out 1: 1 selects memory data into MDR.
- `Mem_CE`, `Mem_OE`, `Mem_WE`, `Mem_UB`, `Mem_LB` out 1 each: SRAM strobes, active-low.

## Operation
- States: HALTED, FETCH1, FETCH2, FETCH3, DECODE, ADD, AND, NOT, BR, BR_TAKEN, JMP, JSR1, JSR2, LDR1, LDR2, LDR3, STR1, STR2, STR3, PAUSE1, PAUSE2.
- HALTED: all loads and gates low, strobes high. Leaves when `Run`=1.
- FETCH1: GatePC, LD_MAR, PCMUX=10, LD_PC.
- FETCH2: Mem_CE=Mem_OE=0, MIO_EN=1. Held `MEM_WAIT` cycles, with LD_MDR on the final one.
- FETCH3: GateMDR, LD_IR.
- DECODE: LD_BEN. Dispatch on IR[15:12]: 0001 ADD, 0101 AND, 1001 NOT, 0000 BR, 1100 JMP, 0100 JSR, 0110 LDR, 0111 STR, 1101 PAUSE. Any other opcode goes to FETCH1 (NOP).
- ADD/AND: SR1MUX=1, ALUK 00/01, GateALU, LD_REG, LD_CC, DRMUX=0. NOT is the same with ALUK=10.
- BR: goes to BR_TAKEN if `BEN`, else FETCH1. BR_TAKEN: ADDR1MUX=1, ADDR2MUX=01, PCMUX=01, LD_PC.
- JMP: SR1MUX=1, ADDR1MUX=0, ADDR2MUX=11, PCMUX=01, LD_PC.
- JSR1: GatePC, DRMUX=1, LD_REG. JSR2: ADDR1MUX=1, ADDR2MUX=00, PCMUX=01, LD_PC.
- LDR1: SR1MUX=1, ADDR1MUX=0, ADDR2MUX=10, GateMARMUX, LD_MAR. LDR2 is a memory read exactly as FETCH2. LDR3: GateMDR, LD_REG, LD_CC, DRMUX=0.
- STR1: same as LDR1. STR2: SR1MUX=0, ALUK=11, GateALU, LD_MDR, MIO_EN=0. STR3: Mem_CE=Mem_WE=0 held `MEM_WAIT` cycles.
- PAUSE1: waits for `Continue`=1. PAUSE2: waits for `Continue`=0, then FETCH1.
- Mem_UB and Mem_LB are 0 whenever Mem_CE=0, otherwise 1.

## Timing
- Moore outputs, decoded from the registered state. The BR decision reads the `BEN` value loaded in DECODE.
- Wait counter is 3 bits. It clears on entry to every memory state and advances while counter < `MEM_WAIT`-1.
- Cycles per instruction with W=`MEM_WAIT`:
  - fetch+decode: W+3
  - ADD/AND/NOT/JMP/BR-not-taken: +1
  - BR-taken/JSR: +2
  - LDR: W+2
  - STR: W+2
- Reset, asynchronous at any point including mid-memory access: state goes to HALTED, counter 0, every load/gate/select output 0, every strobe 1, in the same cycle.
- `Run` is ignored outside HALTED. `Continue` is ignored outside the PAUSE states.

## Configuration
- `LC3_JSR_EN` defined: JSR1/JSR2 exist and opcode 0100 executes.
- `LC3_JSR_EN` undefined: those states are removed and 0100 decodes as a NOP, so DECODE goes straight to FETCH1.

## Structure
- Package `lc3_pkg`:
  - state enum `ctrl_state_t`
  - opcode constants `OP_ADD`…`OP_PAUSE`
  - mux-select constants (`PCMUX_*`, `ADDR2_*`, `ALUK_*`)
- Sub-module `mem_wait_ctr`: 3-bit counter with clear/enable and a `done` output, instanced once.

## Test plan
- Hold reset low, then release with `Run`=0 -> stays HALTED, all loads 0, strobes 1. Pulse `Run` -> FETCH1 asserts GatePC, LD_MAR, LD_PC with PCMUX=10.
- With `MEM_WAIT`=2, IR=16'h1042 (ADD) -> Mem_OE low for exactly 2 cycles, LD_MDR on the second, ADD state has ALUK=00, LD_REG, LD_CC; 6 cycles FETCH1-to-FETCH1.
- IR=16'h0E05 with `BEN`=1 -> BR_TAKEN with PCMUX=01, ADDR2MUX=01, ADDR1MUX=1. With `BEN`=0 -> FETCH1 directly after BR.
- IR=16'h6282 (LDR), then IR=16'h7282 (STR) -> LDR: ADDR2MUX=10, GateMARMUX, read window, LD_REG. STR: ALUK=11, LD_MDR, Mem_WE low for `MEM_WAIT` cycles.
- IR=16'hD000 -> parks in PAUSE1. `Continue` high -> PAUSE2. `Continue` low -> FETCH1.
- Assert `Reset_al` low in the middle of the FETCH2 read -> Mem_OE/Mem_CE go high and state goes HALTED without waiting for a clock edge.
